// File: rtl/digit_entry_if.sv
// rtl/digit_entry_if.sv - setpoint digits and load handshake between digit_entry and the timer
interface digit_entry_if;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic [2:0] digit_count;
    logic       load_valid;
    logic       timer_ready;

    modport master (
        output min_tens, min_units, sec_tens, sec_units, digit_count, load_valid,
        input  timer_ready
    );

    modport slave (
        input  min_tens, min_units, sec_tens, sec_units, digit_count, load_valid,
        output timer_ready
    );
endinterface

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - keypad debounce, MM:SS digit entry and setpoint load; optional DIGIT_ENTRY_CLAMP_EN
module digit_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clearn,
    input  logic [9:0]  keyboard,
    input  logic [3:0]  bcd,
    input  logic        enablen,
    input  logic        start,
    input  logic        cancel,
    digit_entry_if.master tmr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENTRY = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;

    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);

    logic [1:0] state;
    logic [9:0] sync1, sync2, last;
    logic [7:0] cnt;
    logic       armed;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic [2:0] digit_count;

    logic sample_key, sample_idle;
    logic last_key, last_idle;
    logic accept, kept;

    assign sample_idle = (sync2 == 10'd0);
    assign sample_key  = !sample_idle && ((sync2 & (sync2 - 10'd1)) == 10'd0);
    assign last_idle   = (last == 10'd0);
    assign last_key    = !last_idle && ((last & (last - 10'd1)) == 10'd0);

    // The counter saturates at DB, so accept is level-true while a key is held;
    // clearing armed on the accept edge is what suppresses repeats.
    assign accept = armed && last_key && (cnt == DB);
    assign kept   = accept && !enablen && !start && !cancel &&
                    (state == IDLE || state == ENTRY) && (digit_count != 3'd4);

    always_ff @(posedge clock) begin
        if (!clearn) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            sync1 <= keyboard;
            sync2 <= sync1;
            last  <= sync2;
            if (!sample_key && !sample_idle)
                cnt <= '0;
            else if (sync2 == last)
                cnt <= (cnt == DB) ? cnt : cnt + 8'd1;
            else
                cnt <= 8'd1;

            if (accept)
                armed <= 1'b0;
            else if (last_idle && cnt == DB)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clearn) begin
            state       <= IDLE;
            min_tens    <= '0;
            min_units   <= '0;
            sec_tens    <= '0;
            sec_units   <= '0;
            digit_count <= '0;
        end else begin
            case (state)
                IDLE, ENTRY: begin
                    if (state == ENTRY && cancel) begin
                        state       <= IDLE;
                        min_tens    <= '0;
                        min_units   <= '0;
                        sec_tens    <= '0;
                        sec_units   <= '0;
                        digit_count <= '0;
                    end else if (state == ENTRY && start) begin
                        state <= LOAD;
`ifdef DIGIT_ENTRY_CLAMP_EN
                        if (sec_tens > 4'd5) begin
                            sec_tens  <= 4'd5;
                            sec_units <= 4'd9;
                        end
`endif
                    end else if (kept) begin
                        state       <= ENTRY;
                        min_tens    <= min_units;
                        min_units   <= sec_tens;
                        sec_tens    <= sec_units;
                        sec_units   <= bcd;
                        digit_count <= digit_count + 3'd1;
                    end
                end
                LOAD: begin
                    if (tmr.timer_ready) begin
                        state       <= IDLE;
                        min_tens    <= '0;
                        min_units   <= '0;
                        sec_tens    <= '0;
                        sec_units   <= '0;
                        digit_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tmr.min_tens    = min_tens;
    assign tmr.min_units   = min_units;
    assign tmr.sec_tens    = sec_tens;
    assign tmr.sec_units   = sec_units;
    assign tmr.digit_count = digit_count;
    assign tmr.load_valid  = (state == LOAD);

endmodule

// File: tb/tb_digit_entry.sv
// tb/tb_digit_entry.sv - directed self-checking bench for digit_entry
module tb_digit_entry;
    logic       clock = 1'b0;
    logic       clearn = 1'b0;
    logic [9:0] keyboard = '0;
    logic [3:0] bcd;
    logic       enablen = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;

    int checks = 0;
    int failures = 0;

    digit_entry_if tif ();

    digit_entry #(.DEBOUNCE_CYCLES(4)) dut (
        .clock    (clock),
        .clearn   (clearn),
        .keyboard (keyboard),
        .bcd      (bcd),
        .enablen  (enablen),
        .start    (start),
        .cancel   (cancel),
        .tmr      (tif.master)
    );

    always #5 clock = ~clock;

    // Encoder model feeding bcd from the same keypad bus
    always_comb begin
        bcd = 4'd0;
        for (int i = 0; i < 10; i++)
            if (keyboard[i]) bcd = 4'(i);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        clearn = 1'b0;
        keyboard = '0;
        start = 1'b0;
        cancel = 1'b0;
        enablen = 1'b0;
        tif.timer_ready = 1'b0;
        tick();
        clearn = 1'b1;
        tick();
    endtask

    task automatic press(input int k, input int hold, input int rel);
        keyboard = 10'd1 << k;
        repeat (hold) tick();
        keyboard = '0;
        repeat (rel) tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (tif.min_tens !== 4'd0) begin failures++; $display("FAIL reset_min_tens got=%0d exp=0", tif.min_tens); end
        if (tif.sec_units !== 4'd0) begin failures++; $display("FAIL reset_sec_units got=%0d exp=0", tif.sec_units); end
        if (tif.digit_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", tif.digit_count); end
        if (tif.load_valid !== 1'b0) begin failures++; $display("FAIL reset_load_valid got=%0b exp=0", tif.load_valid); end
        if (tif.sec_tens !== 4'd0) begin failures++; $display("FAIL reset_sec_tens got=%0d exp=0", tif.sec_tens); end
    endtask

    task automatic test_latency_two_keys();
        do_reset();
        keyboard = 10'd1 << 3;
        repeat (6) tick();
        checks++;
        if (tif.digit_count !== 3'd0) begin failures++; $display("FAIL latency_early got=%0d exp=0", tif.digit_count); end
        tick();
        checks += 2;
        if (tif.digit_count !== 3'd1) begin failures++; $display("FAIL latency_count got=%0d exp=1", tif.digit_count); end
        if (tif.sec_units !== 4'd3) begin failures++; $display("FAIL latency_digit got=%0d exp=3", tif.sec_units); end
        repeat (3) tick();
        keyboard = '0;
        repeat (10) tick();
        press(7, 10, 10);
        checks += 3;
        if (tif.sec_tens !== 4'd3) begin failures++; $display("FAIL two_keys_sec_tens got=%0d exp=3", tif.sec_tens); end
        if (tif.sec_units !== 4'd7) begin failures++; $display("FAIL two_keys_sec_units got=%0d exp=7", tif.sec_units); end
        if (tif.digit_count !== 3'd2) begin failures++; $display("FAIL two_keys_count got=%0d exp=2", tif.digit_count); end
    endtask

    task automatic test_hold_and_bounce();
        do_reset();
        press(5, 50, 10);
        checks += 2;
        if (tif.digit_count !== 3'd1) begin failures++; $display("FAIL hold_count got=%0d exp=1", tif.digit_count); end
        if (tif.sec_units !== 4'd5) begin failures++; $display("FAIL hold_digit got=%0d exp=5", tif.sec_units); end
        do_reset();
        keyboard = 10'd1 << 8;
        repeat (2) tick();
        keyboard = '0;
        tick();
        press(8, 10, 10);
        checks += 2;
        if (tif.digit_count !== 3'd1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", tif.digit_count); end
        if (tif.sec_units !== 4'd8) begin failures++; $display("FAIL bounce_digit got=%0d exp=8", tif.sec_units); end
    endtask

    task automatic test_full_and_enable();
        do_reset();
        for (int k = 1; k <= 5; k++) press(k, 10, 10);
        checks += 5;
        if (tif.min_tens !== 4'd1) begin failures++; $display("FAIL full_min_tens got=%0d exp=1", tif.min_tens); end
        if (tif.min_units !== 4'd2) begin failures++; $display("FAIL full_min_units got=%0d exp=2", tif.min_units); end
        if (tif.sec_tens !== 4'd3) begin failures++; $display("FAIL full_sec_tens got=%0d exp=3", tif.sec_tens); end
        if (tif.sec_units !== 4'd4) begin failures++; $display("FAIL full_sec_units got=%0d exp=4", tif.sec_units); end
        if (tif.digit_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", tif.digit_count); end
        do_reset();
        press(2, 10, 10);
        enablen = 1'b1;
        press(6, 10, 10);
        enablen = 1'b0;
        checks += 2;
        if (tif.digit_count !== 3'd1) begin failures++; $display("FAIL enablen_count got=%0d exp=1", tif.digit_count); end
        if (tif.sec_units !== 4'd2) begin failures++; $display("FAIL enablen_digit got=%0d exp=2", tif.sec_units); end
        press(6, 10, 10);
        checks += 2;
        if (tif.digit_count !== 3'd2) begin failures++; $display("FAIL reenable_count got=%0d exp=2", tif.digit_count); end
        if (tif.sec_units !== 4'd6) begin failures++; $display("FAIL reenable_digit got=%0d exp=6", tif.sec_units); end
    endtask

    task automatic test_load();
        int highs;
        logic [3:0] exp_tens;
`ifdef DIGIT_ENTRY_CLAMP_EN
        exp_tens = 4'd5;
`else
        exp_tens = 4'd9;
`endif
        do_reset();
        press(9, 10, 10);
        press(9, 10, 10);
        start = 1'b1;
        checks++;
        if (tif.load_valid !== 1'b0) begin failures++; $display("FAIL load_before_start got=%0b exp=0", tif.load_valid); end
        tick();
        start = 1'b0;
        checks += 3;
        if (tif.load_valid !== 1'b1) begin failures++; $display("FAIL load_rise got=%0b exp=1", tif.load_valid); end
        if (tif.sec_tens !== exp_tens) begin failures++; $display("FAIL load_sec_tens got=%0d exp=%0d", tif.sec_tens, exp_tens); end
        if (tif.sec_units !== 4'd9) begin failures++; $display("FAIL load_sec_units got=%0d exp=9", tif.sec_units); end
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            if (tif.load_valid !== 1'b1) break;
            highs++;
            tif.timer_ready = (i >= 5);
            cancel = (i == 2);
            tick();
            cancel = 1'b0;
        end
        tif.timer_ready = 1'b0;
        checks += 4;
        if (highs !== 6) begin failures++; $display("FAIL load_high_cycles got=%0d exp=6", highs); end
        if (tif.sec_units !== 4'd0) begin failures++; $display("FAIL load_clear_units got=%0d exp=0", tif.sec_units); end
        if (tif.sec_tens !== 4'd0) begin failures++; $display("FAIL load_clear_tens got=%0d exp=0", tif.sec_tens); end
        if (tif.digit_count !== 3'd0) begin failures++; $display("FAIL load_clear_count got=%0d exp=0", tif.digit_count); end
    endtask

    task automatic test_cancel_start();
        do_reset();
        press(4, 10, 10);
        start = 1'b1;
        cancel = 1'b1;
        tick();
        start = 1'b0;
        cancel = 1'b0;
        checks += 3;
        if (tif.load_valid !== 1'b0) begin failures++; $display("FAIL cancel_start_valid got=%0b exp=0", tif.load_valid); end
        if (tif.digit_count !== 3'd0) begin failures++; $display("FAIL cancel_start_count got=%0d exp=0", tif.digit_count); end
        if (tif.sec_units !== 4'd0) begin failures++; $display("FAIL cancel_start_digit got=%0d exp=0", tif.sec_units); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (tif.load_valid !== 1'b0) begin failures++; $display("FAIL idle_start_ignored got=%0b exp=0", tif.load_valid); end
    endtask

    task automatic test_reset_in_load();
        do_reset();
        press(1, 10, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (tif.load_valid !== 1'b1) begin failures++; $display("FAIL rst_load_entered got=%0b exp=1", tif.load_valid); end
        clearn = 1'b0;
        tick();
        checks += 3;
        if (tif.load_valid !== 1'b0) begin failures++; $display("FAIL rst_load_valid got=%0b exp=0", tif.load_valid); end
        if (tif.sec_units !== 4'd0) begin failures++; $display("FAIL rst_load_digit got=%0d exp=0", tif.sec_units); end
        if (tif.digit_count !== 3'd0) begin failures++; $display("FAIL rst_load_count got=%0d exp=0", tif.digit_count); end
        clearn = 1'b1;
        tick();
    endtask

    initial begin
        tif.timer_ready = 1'b0;
        test_reset();
        test_latency_two_keys();
        test_hold_and_bounce();
        test_full_and_enable();
        test_load();
        test_cancel_start();
        test_reset_in_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
